// File: rtl/anyedge_flag_checker_if.sv
// Signal bundle between the flag-sequencing stage and the any-edge flag checker.
// The slave side is the checker; the master side drives the flags and observes status.
interface anyedge_flag_checker_if #(
  parameter int unsigned CNT_W = 8
);
  logic             en;
  logic             clr;
  logic             flag_a;
  logic             flag_b;
  logic             busy;
  logic             pass_pulse;
  logic             fail_pulse;
  logic [1:0]       fail_code;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic             err_sticky;

  modport master (
    output en, clr, flag_a, flag_b,
    input  busy, pass_pulse, fail_pulse, fail_code, pass_cnt, fail_cnt, err_sticky
  );

  modport slave (
    input  en, clr, flag_a, flag_b,
    output busy, pass_pulse, fail_pulse, fail_code, pass_cnt, fail_cnt, err_sticky
  );
endinterface

// File: rtl/anyedge_flag_checker.sv
// Checks that flag_b is 0 on every flag_a edge and 1 exactly CHECK_DELAY cycles later,
// reporting registered pass/fail pulses, saturating counters and a sticky error bit.
module anyedge_flag_checker #(
  parameter int unsigned CHECK_DELAY = 25,
  parameter int unsigned DLY_W       = 8,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  anyedge_flag_checker_if.slave  chk_io
);

  typedef enum logic {StIdle, StWait} state_e;

  localparam logic [DLY_W-1:0] DlyLoad = DLY_W'(CHECK_DELAY - 1);

  state_e           state_q, state_d;
  logic             armed_q, armed_d;
  logic             flag_a_q;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic [1:0]       code_q, code_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             err_q, err_d;
  logic             edge_det;
  logic             fresh;

  // armed_q holds off detection until flag_a_q has seen one real sample.
  assign edge_det = chk_io.en & armed_q & (chk_io.flag_a ^ flag_a_q);
  assign armed_d  = armed_q | chk_io.en;

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    pass_d  = 1'b0;
    fail_d  = 1'b0;
    code_d  = 2'b00;
    fresh   = 1'b0;
    unique case (state_q)
      StIdle: fresh = edge_det;
      StWait: begin
        if (!chk_io.en) begin
          state_d = StIdle;
        end else if (dly_q == '0) begin
          // Completing check resolves first; a same-cycle edge is then a fresh first check.
          state_d = StIdle;
          if (chk_io.flag_b) begin
            pass_d = 1'b1;
          end else begin
            fail_d = 1'b1;
            code_d = 2'b10;
          end
          fresh = edge_det;
        end else if (edge_det) begin
          state_d = StIdle;
          fail_d  = 1'b1;
          code_d  = 2'b11;
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (fresh) begin
      if (!chk_io.flag_b) begin
        state_d = StWait;
        dly_d   = DlyLoad;
      end else begin
        fail_d = 1'b1;
        code_d = 2'b01;
      end
    end
  end

  always_comb begin
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    err_d      = err_q;
    if (chk_io.clr) begin
      pass_cnt_d = '0;
      fail_cnt_d = '0;
      err_d      = 1'b0;
    end else begin
      if (pass_d && (pass_cnt_q != '1)) pass_cnt_d = pass_cnt_q + 1'b1;
      if (fail_d && (fail_cnt_q != '1)) fail_cnt_d = fail_cnt_q + 1'b1;
      if (fail_d) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      armed_q    <= 1'b0;
      flag_a_q   <= 1'b0;
      dly_q      <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      code_q     <= 2'b00;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      flag_a_q   <= chk_io.flag_a;
      dly_q      <= dly_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      code_q     <= code_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      err_q      <= err_d;
    end
  end

  assign chk_io.busy       = (state_q == StWait);
  assign chk_io.pass_pulse = pass_q;
  assign chk_io.fail_pulse = fail_q;
  assign chk_io.fail_code  = code_q;
  assign chk_io.pass_cnt   = pass_cnt_q;
  assign chk_io.fail_cnt   = fail_cnt_q;
  assign chk_io.err_sticky = err_q;

endmodule

// File: tb/tb_anyedge_flag_checker.sv
// Bench for anyedge_flag_checker: a CHECK_DELAY=25/CNT_W=8 instance and a
// CHECK_DELAY=1/CNT_W=2 instance share one stimulus stream and one deadline-based model.
module tb_anyedge_flag_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  anyedge_flag_checker_if #(.CNT_W(8)) if0 ();
  anyedge_flag_checker_if #(.CNT_W(2)) if1 ();

  anyedge_flag_checker #(.CHECK_DELAY(25), .DLY_W(8), .CNT_W(8)) u_dut0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .chk_io (if0)
  );

  anyedge_flag_checker #(.CHECK_DELAY(1), .DLY_W(8), .CNT_W(2)) u_dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .chk_io (if1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  bit en_v = 1'b0, clr_v = 1'b0, fa_v = 1'b0, fb_v = 1'b0;

  // Model: a pending check is an absolute cycle deadline rather than a countdown.
  int unsigned cyc;
  bit          armed, prev_fa;
  bit          pend[2];
  int unsigned dl[2];
  bit          ep[2], ef[2], err[2];
  logic [1:0]  ec[2];
  logic [7:0]  pc[2], fc[2];
  int unsigned dly_p[2] = '{25, 1};
  logic [7:0]  maxc[2]  = '{8'hff, 8'h03};

  logic [5:0] st0, st1;
  assign st0 = {if0.busy, if0.pass_pulse, if0.fail_pulse, if0.fail_code, if0.err_sticky};
  assign st1 = {if1.busy, if1.pass_pulse, if1.fail_pulse, if1.fail_code, if1.err_sticky};

  task automatic model_reset();
    cyc = 0; armed = 0; prev_fa = 0;
    for (int u = 0; u < 2; u++) begin
      pend[u] = 0; dl[u] = 0; ep[u] = 0; ef[u] = 0; err[u] = 0;
      ec[u] = 2'b00; pc[u] = 8'd0; fc[u] = 8'd0;
    end
  endtask

  task automatic model_step();
    bit edge_seen;
    bit fresh;
    edge_seen = en_v && armed && (fa_v != prev_fa);
    for (int u = 0; u < 2; u++) begin
      ep[u] = 0; ef[u] = 0; ec[u] = 2'b00;
      fresh = edge_seen;
      if (pend[u]) begin
        fresh = 0;
        if (!en_v) begin
          pend[u] = 0;
        end else if (cyc == dl[u]) begin
          pend[u] = 0;
          if (fb_v) ep[u] = 1;
          else begin ef[u] = 1; ec[u] = 2'b10; end
          fresh = edge_seen;
        end else if (edge_seen) begin
          pend[u] = 0; ef[u] = 1; ec[u] = 2'b11;
        end
      end
      if (fresh) begin
        if (!fb_v) begin pend[u] = 1; dl[u] = cyc + dly_p[u]; end
        else begin ef[u] = 1; ec[u] = 2'b01; end
      end
      if (clr_v) begin
        pc[u] = 8'd0; fc[u] = 8'd0; err[u] = 0;
      end else begin
        if (ep[u] && pc[u] < maxc[u]) pc[u] = pc[u] + 8'd1;
        if (ef[u] && fc[u] < maxc[u]) fc[u] = fc[u] + 8'd1;
        if (ef[u]) err[u] = 1;
      end
    end
    armed = armed | en_v;
    prev_fa = fa_v;
    cyc++;
  endtask

  task automatic tick(input bit en, input bit clr, input bit fa, input bit fb);
    @(negedge clk);
    en_v = en; clr_v = clr; fa_v = fa; fb_v = fb;
    if0.en = en; if0.clr = clr; if0.flag_a = fa; if0.flag_b = fb;
    if1.en = en; if1.clr = clr; if1.flag_a = fa; if1.flag_b = fb;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en_v = 0; clr_v = 0; fa_v = 0; fb_v = 0;
    if0.en = 0; if0.clr = 0; if0.flag_a = 0; if0.flag_b = 0;
    if1.en = 0; if1.clr = 0; if1.flag_a = 0; if1.flag_b = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (st0 !== 6'd0 || if0.pass_cnt !== 8'd0 || if0.fail_cnt !== 8'd0 || st1 !== 6'd0 ||
        if1.pass_cnt !== 2'd0 || if1.fail_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: st0=%b st1=%b cnt0=%0d/%0d want all zero",
               st0, st1, if0.pass_cnt, if0.fail_cnt);
    end
    tick(1, 0, 0, 0);
    n_tests++;
    if (st0 !== 6'd0) begin
      n_fail++; $display("FAIL arm_cycle: st0=%b want 000000", st0);
    end
  endtask

  task automatic test_nominal(input bit new_fa, input logic [7:0] exp_pc);
    tick(1, 0, new_fa, 0);
    n_tests++;
    if (if0.busy !== 1'b1 || if0.fail_pulse !== 1'b0) begin
      n_fail++; $display("FAIL nominal_start: busy=%b fail=%b want 1/0", if0.busy, if0.fail_pulse);
    end
    for (int i = 1; i <= 25; i++) begin
      tick(1, 0, new_fa, (i > 10));
      n_tests++;
      if (i < 25) begin
        if (if0.busy !== 1'b1 || if0.pass_pulse !== 1'b0 || if0.fail_pulse !== 1'b0) begin
          n_fail++;
          $display("FAIL nominal_wait[%0d]: busy=%b pass=%b fail=%b want 1/0/0",
                   i, if0.busy, if0.pass_pulse, if0.fail_pulse);
        end
      end else if (if0.pass_pulse !== 1'b1 || if0.busy !== 1'b0 || if0.fail_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL nominal_pass: pass=%b busy=%b fail=%b want 1/0/0",
                 if0.pass_pulse, if0.busy, if0.fail_pulse);
      end
    end
    tick(1, 0, new_fa, 0);
    n_tests++;
    if (if0.pass_pulse !== 1'b0 || if0.pass_cnt !== exp_pc || if0.fail_cnt !== 8'd0 ||
        if0.err_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_after: pass=%b pass_cnt=%0d fail_cnt=%0d err=%b want 0/%0d/0/0",
               if0.pass_pulse, if0.pass_cnt, if0.fail_cnt, if0.err_sticky, exp_pc);
    end
  endtask

  task automatic test_first_fail();
    tick(1, 0, !fa_v, 1);
    n_tests++;
    if (if0.fail_pulse !== 1'b1 || if0.fail_code !== 2'b01 || if0.busy !== 1'b0 ||
        if0.err_sticky !== 1'b1 || if0.fail_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL first_fail: fail=%b code=%b busy=%b err=%b fcnt=%0d want 1/01/0/1/1",
               if0.fail_pulse, if0.fail_code, if0.busy, if0.err_sticky, if0.fail_cnt);
    end
    tick(1, 1, fa_v, 0);
    n_tests++;
    if (if0.fail_cnt !== 8'd0 || if0.pass_cnt !== 8'd0 || if0.err_sticky !== 1'b0 ||
        if0.fail_pulse !== 1'b0 || if0.fail_code !== 2'b00) begin
      n_fail++;
      $display("FAIL clr: fcnt=%0d pcnt=%0d err=%b fail=%b code=%b want 0/0/0/0/00",
               if0.fail_cnt, if0.pass_cnt, if0.err_sticky, if0.fail_pulse, if0.fail_code);
    end
  endtask

  task automatic test_second_fail();
    tick(1, 0, !fa_v, 0);
    repeat (25) tick(1, 0, fa_v, 0);
    n_tests++;
    if (if0.fail_pulse !== 1'b1 || if0.fail_code !== 2'b10 || if0.pass_pulse !== 1'b0 ||
        if0.busy !== 1'b0 || if0.fail_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL second_fail: fail=%b code=%b pass=%b busy=%b fcnt=%0d want 1/10/0/0/1",
               if0.fail_pulse, if0.fail_code, if0.pass_pulse, if0.busy, if0.fail_cnt);
    end
  endtask

  task automatic test_retrigger();
    bit quiet;
    tick(1, 0, !fa_v, 0);
    repeat (11) tick(1, 0, fa_v, 0);
    tick(1, 0, !fa_v, 0);
    n_tests++;
    if (if0.fail_pulse !== 1'b1 || if0.fail_code !== 2'b11 || if0.busy !== 1'b0 ||
        if0.pass_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL retrigger: fail=%b code=%b busy=%b pass=%b want 1/11/0/0",
               if0.fail_pulse, if0.fail_code, if0.busy, if0.pass_pulse);
    end
    quiet = 1;
    for (int i = 0; i < 20; i++) begin
      tick(1, 0, fa_v, (i >= 10));
      if (if0.busy !== 1'b0 || if0.pass_pulse !== 1'b0 || if0.fail_pulse !== 1'b0) quiet = 0;
    end
    n_tests++;
    if (!quiet) begin
      n_fail++; $display("FAIL retrigger_no_check: activity=1 want 0");
    end
  endtask

  task automatic test_simultaneous();
    tick(1, 0, !fa_v, 0);
    repeat (24) tick(1, 0, fa_v, 0);
    tick(1, 0, !fa_v, 1);
    n_tests++;
    if (if0.pass_pulse !== 1'b1 || if0.fail_pulse !== 1'b1 || if0.fail_code !== 2'b01 ||
        if0.busy !== 1'b0 || if0.pass_cnt !== pc[0] || if0.fail_cnt !== fc[0]) begin
      n_fail++;
      $display("FAIL simultaneous: pass=%b fail=%b code=%b busy=%b pcnt=%0d fcnt=%0d want 1/1/01/0/%0d/%0d",
               if0.pass_pulse, if0.fail_pulse, if0.fail_code, if0.busy, if0.pass_cnt,
               if0.fail_cnt, pc[0], fc[0]);
    end
  endtask

  task automatic test_delay1_sat();
    do_reset();
    tick(1, 0, 0, 0);
    for (int n = 0; n < 5; n++) begin
      tick(1, 0, !fa_v, 0);
      n_tests++;
      if (if1.busy !== 1'b1) begin
        n_fail++; $display("FAIL d1_busy[%0d]: busy=%b want 1", n, if1.busy);
      end
      tick(1, 0, fa_v, 1);
      n_tests++;
      if (if1.pass_pulse !== 1'b1 || if1.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL d1_pass[%0d]: pass=%b busy=%b want 1/0", n, if1.pass_pulse, if1.busy);
      end
    end
    n_tests++;
    if (if1.pass_cnt !== 2'd3 || if1.fail_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL saturate: pass_cnt=%0d fail_cnt=%0d want 3/0", if1.pass_cnt, if1.fail_cnt);
    end
  endtask

  task automatic test_reset_mid_wait();
    tick(1, 0, !fa_v, 0);
    repeat (5) tick(1, 0, fa_v, 0);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (st0 !== 6'd0 || if0.pass_cnt !== 8'd0 || if0.fail_cnt !== 8'd0 || st1 !== 6'd0 ||
        if1.pass_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL async_reset: st0=%b st1=%b cnt0=%0d/%0d want all zero",
               st0, st1, if0.pass_cnt, if0.fail_cnt);
    end
    do_reset();
    tick(1, 0, 1, 0);
    n_tests++;
    if (st0 !== 6'd0 || st1 !== 6'd0) begin
      n_fail++; $display("FAIL no_edge_after_reset: st0=%b st1=%b want 0", st0, st1);
    end
    tick(1, 0, 0, 0);
    n_tests++;
    if (if0.busy !== 1'b1) begin
      n_fail++; $display("FAIL edge_after_arm: busy=%b want 1", if0.busy);
    end
  endtask

  task automatic test_enable();
    bit quiet;
    repeat (3) tick(1, 0, fa_v, 0);
    tick(0, 0, fa_v, 1);
    n_tests++;
    if (st0 !== 6'd0 || if0.pass_cnt !== 8'd0 || if0.fail_cnt !== 8'd0) begin
      n_fail++; $display("FAIL en_abort: st0=%b want 000000", st0);
    end
    quiet = 1;
    for (int i = 0; i < 30; i++) begin
      tick(0, 0, (i % 7 == 3) ? !fa_v : fa_v, i[0]);
      if (if0.busy !== 1'b0 || if0.pass_pulse !== 1'b0 || if0.fail_pulse !== 1'b0) quiet = 0;
    end
    n_tests++;
    if (!quiet) begin
      n_fail++; $display("FAIL en_low_quiet: activity=1 want 0");
    end
    tick(1, 0, fa_v, 0);
    tick(1, 0, !fa_v, 0);
    n_tests++;
    if (if0.busy !== 1'b1 || if0.fail_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL armed_kept: busy=%b fail=%b want 1/0", if0.busy, if0.fail_pulse);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      tick(($urandom_range(0, 15) != 0), ($urandom_range(0, 63) == 0),
           ($urandom_range(0, 11) == 0) ? !fa_v : fa_v, 1'($urandom_range(0, 1)));
      n_tests++;
      if (st0 !== {pend[0], ep[0], ef[0], ec[0], err[0]} || if0.pass_cnt !== pc[0] ||
          if0.fail_cnt !== fc[0]) begin
        n_fail++;
        if (bad < 10) $display("FAIL random_d25[%0d]: st=%b cnt=%0d/%0d want st=%b cnt=%0d/%0d",
                               i, st0, if0.pass_cnt, if0.fail_cnt,
                               {pend[0], ep[0], ef[0], ec[0], err[0]}, pc[0], fc[0]);
        bad++;
      end
      n_tests++;
      if (st1 !== {pend[1], ep[1], ef[1], ec[1], err[1]} || {6'd0, if1.pass_cnt} !== pc[1] ||
          {6'd0, if1.fail_cnt} !== fc[1]) begin
        n_fail++;
        if (bad < 10) $display("FAIL random_d1[%0d]: st=%b cnt=%0d/%0d want st=%b cnt=%0d/%0d",
                               i, st1, if1.pass_cnt, if1.fail_cnt,
                               {pend[1], ep[1], ef[1], ec[1], err[1]}, pc[1], fc[1]);
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal(1'b1, 8'd1);
    test_nominal(1'b0, 8'd2);
    test_first_fail();
    test_second_fail();
    test_retrigger();
    test_simultaneous();
    test_delay1_sat();
    test_reset_mid_wait();
    test_enable();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
